// File: rtl/alu_defs.sv
// Shared ALU definitions: arith_unit opcodes and the multiply/divide
// sequencer state and operation encodings.
package alu_defs;

    // arith_unit operation select
    typedef enum logic [1:0] {
        ARITH_ADD = 2'd0,
        ARITH_SUB = 2'd1,
        MOV_      = 2'd2
    } arith_op_e;

    // Multiply/divide sequencer FSM states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Multiply/divide operation select
    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_e;

endpackage

// File: rtl/arith_unit.sv
// Combinational N-bit add/subtract unit. cout_o is the carry out for
// ARITH_ADD and the borrow out for ARITH_SUB; overflow_o is the signed
// overflow flag. MOV_ passes a_i through with no carry.
module arith_unit
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  arith_op_e      op_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [N-1:0]   sum_o,
    output logic           cout_o,
    output logic           overflow_o
);

    logic [N:0] res;

    // Select the operation and derive carry/borrow and signed overflow
    always_comb begin
        res        = {1'b0, a_i};
        overflow_o = 1'b0;
        case (op_i)
            ARITH_ADD: begin
                res        = {1'b0, a_i} + {1'b0, b_i};
                overflow_o = (a_i[N-1] == b_i[N-1]) && (res[N-1] != a_i[N-1]);
            end
            ARITH_SUB: begin
                res        = {1'b0, a_i} - {1'b0, b_i};
                overflow_o = (a_i[N-1] != b_i[N-1]) && (res[N-1] != a_i[N-1]);
            end
            default: begin
                res        = {1'b0, a_i};
                overflow_o = 1'b0;
            end
        endcase
    end

    assign sum_o  = res[N-1:0];
    assign cout_o = res[N];

endmodule

// File: rtl/arith_muldiv_seq.sv
// Multi-cycle unsigned multiply / divide sequencer. One result bit is
// produced per cycle through a single arith_unit: shift-add for MUL,
// restoring shift-subtract for DIV. The {hi, lo} register pair is both the
// iteration state and the result; it holds its value until the next
// accepted start.
module arith_muldiv_seq
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_hi_o,
    output logic [N-1:0] result_lo_o,
    output logic         div_by_zero_o
);

    localparam int CW = $clog2(N + 1);

    md_state_e    state_q;
    md_op_e       op_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0] hi_q;
    logic [N-1:0] lo_q;
    // Multiplicand for MUL, divisor for DIV
    logic [N-1:0] opnd_q;
    logic         dbz_q;

    // Datapath for one iteration
    arith_op_e    alu_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_sum;
    logic         alu_cout;
    logic         unused_alu_ovf;

    logic         sh_msb;
    logic [N-1:0] hi_s;
    logic [N-1:0] lo_s;
    logic [N-1:0] iter_hi;
    logic [N-1:0] iter_lo;

    // Left shift of the {hi, lo} pair for the divide step; sh_msb is the
    // bit shifted out of hi, which forces acceptance of the trial subtract
    assign {sh_msb, hi_s, lo_s} = {hi_q, lo_q, 1'b0};

    arith_unit #(.N(N)) u_arith (
        .op_i       (alu_op),
        .a_i        (alu_a),
        .b_i        (opnd_q),
        .sum_o      (alu_sum),
        .cout_o     (alu_cout),
        .overflow_o (unused_alu_ovf)
    );

    // Drive the arith_unit only while iterating; idle it with MOV_ otherwise
    always_comb begin
        alu_op = MOV_;
        alu_a  = hi_q;
        if (state_q == MD_CALC) begin
            if (op_q == MD_MUL) begin
                alu_op = ARITH_ADD;
                alu_a  = hi_q;
            end else begin
                alu_op = ARITH_SUB;
                alu_a  = hi_s;
            end
        end
    end

    // Next {hi, lo} for one shift-add or restoring shift-subtract step
    always_comb begin
        iter_hi = hi_q;
        iter_lo = lo_q;
        if (op_q == MD_MUL) begin
            if (lo_q[0]) begin
                iter_hi = {alu_cout, alu_sum[N-1:1]};
                iter_lo = {alu_sum[0], lo_q[N-1:1]};
            end else begin
                iter_hi = {1'b0, hi_q[N-1:1]};
                iter_lo = {hi_q[0], lo_q[N-1:1]};
            end
        end else begin
            if (sh_msb || !alu_cout) begin
                iter_hi = alu_sum;
                iter_lo = {lo_s[N-1:1], 1'b1};
            end else begin
                iter_hi = hi_s;
                iter_lo = lo_s;
            end
        end
    end

    // FSM, iteration counter and hi/lo shift registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE, MD_DONE: begin
                    state_q <= MD_IDLE;
                    if (start_i) begin
                        op_q  <= md_op_e'(op_i);
                        cnt_q <= CW'(N);
                        dbz_q <= 1'b0;
                        hi_q  <= '0;
                        if (md_op_e'(op_i) == MD_DIV) begin
                            opnd_q <= b_i;
                            if (b_i == '0) begin
                                // Divide by zero finishes immediately
                                state_q <= MD_DONE;
                                cnt_q   <= '0;
                                hi_q    <= a_i;
                                lo_q    <= '1;
                                dbz_q   <= 1'b1;
                            end else begin
                                state_q <= MD_CALC;
                                lo_q    <= a_i;
                            end
                        end else begin
                            state_q <= MD_CALC;
                            opnd_q  <= a_i;
                            lo_q    <= b_i;
                        end
                    end
                end
                MD_CALC: begin
                    hi_q  <= iter_hi;
                    lo_q  <= iter_lo;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= MD_DONE;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = (state_q == MD_CALC);
    assign done_o        = (state_q == MD_DONE);
    assign result_hi_o   = hi_q;
    assign result_lo_o   = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule
